// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, flag bit positions,
// opcode encoding and the response-register FSM states.
package alu_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int FLAG_W_DEF = 4;

   localparam int FLAG_Z   = 0;
   localparam int FLAG_N   = 1;
   localparam int FLAG_C   = 2;
   localparam int FLAG_RSV = 3;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SETC   = 3'b001,
      OP_SUB    = 3'b010,
      OP_AND    = 3'b011,
      OP_NOT    = 3'b100,
      OP_PASS_A = 3'b101,
      OP_PASS_B = 3'b110,
      OP_NOP    = 3'b111
   } alu_op_e;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

   // Pass-through and nop ops leave the architectural flags untouched.
   function automatic logic op_updates_flags(input logic [2:0] op);
      return !(op inside {OP_PASS_A, OP_PASS_B, OP_NOP});
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle for the ALU arbiter: two requester ports, the ALU-side
// operand/result path, the response port and the architectural flags.
//   slave  : the arbiter side (drives ready, ALU inputs, response, flags_q)
//   master : the environment side (requesters, ALU, response consumer)
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FLAG_W = FLAG_W_DEF
) ();

   logic              req0_valid;
   logic              req0_ready;
   logic [2:0]        req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;

   logic              req1_valid;
   logic              req1_ready;
   logic [2:0]        req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;

   logic [DATA_W-1:0] alu_operand1;
   logic [DATA_W-1:0] alu_operand2;
   logic [2:0]        alu_operation;
   logic [FLAG_W-1:0] alu_flags_in;
   logic [DATA_W-1:0] alu_result;
   logic [FLAG_W-1:0] alu_flags_out;

   logic              rsp_valid;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_result;
   logic [FLAG_W-1:0] rsp_flags;
   logic              rsp_ready;

   logic [FLAG_W-1:0] flags_q;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  alu_result, alu_flags_out, rsp_ready,
      output req0_ready, req1_ready,
      output alu_operand1, alu_operand2, alu_operation, alu_flags_in,
      output rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output alu_result, alu_flags_out, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_operand1, alu_operand2, alu_operation, alu_flags_in,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q
   );

endinterface

// File: rtl/arb2_rr.sv
// Two-input arbiter. Grants at most one requester while en is high.
// Default: round-robin, pointer favours req0 out of reset and moves to the
// other requester after every grant.
// Build option ALU_ARB_FIXED_PRIO_EN: req0 always wins, no pointer (and no
// clock/reset ports, since there is no state).
// Ports: clk, reset_b (round-robin build only), en, req[1:0], gnt[1:0].
module arb2_rr (
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
   input  logic       clk,
   input  logic       reset_b,
`endif
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[0])      gnt = 2'b01;
         else if (req[1]) gnt = 2'b10;
      end
   end

`else

   logic ptr_q;   // 1 = req1 favoured on contention

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[0] && (!req[1] || !ptr_q)) gnt = 2'b01;
         else if (req[1])                   gnt = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)    ptr_q <= 1'b0;
      else if (gnt[0]) ptr_q <= 1'b1;
      else if (gnt[1]) ptr_q <= 1'b0;
   end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one combinational ALU and captures the
// result in a single-entry response register. Owns the architectural flag
// register that is fed back to the ALU.
// Ports: clk, reset_b (async, active low), bus (alu_arbiter_if.slave).
// Build option ALU_ARB_FIXED_PRIO_EN: fixed req0 priority instead of
// round-robin.
//
// state     | meaning
// RSP_EMPTY | no response held; any valid request is accepted
// RSP_FULL  | response held on rsp_*; accept only when it drains this cycle
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FLAG_W = FLAG_W_DEF
) (
   input  logic         clk,
   input  logic         reset_b,
   alu_arbiter_if.slave bus
);

   rsp_state_e        state_q, state_d;
   logic              can_accept;
   logic              accept;
   logic              drain;
   logic [1:0]        req_vld;
   logic [1:0]        gnt;
   logic [2:0]        sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic              rsp_id_q;
   logic [DATA_W-1:0] rsp_result_q;
   logic [FLAG_W-1:0] rsp_flags_q;
   logic [FLAG_W-1:0] flags_q;

   assign req_vld = {bus.req1_valid, bus.req0_valid};

   arb2_rr u_arb (
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
      .clk     (clk),
      .reset_b (reset_b),
`endif
      .en      (can_accept),
      .req     (req_vld),
      .gnt     (gnt)
   );

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) state_q <= RSP_EMPTY;
      else          state_q <= state_d;
   end

   // reset_b gates acceptance so no ready leaks out while reset is held.
   always_comb begin
      state_d    = state_q;
      can_accept = 1'b0;
      drain      = 1'b0;
      accept     = 1'b0;
      case (state_q)
         RSP_EMPTY: can_accept = reset_b;
         RSP_FULL: begin
            drain      = bus.rsp_ready;
            can_accept = reset_b && bus.rsp_ready;
         end
         default: state_d = RSP_EMPTY;
      endcase
      accept = can_accept && (|req_vld);
      if (accept)     state_d = RSP_FULL;
      else if (drain) state_d = RSP_EMPTY;
   end

   always_comb begin
      sel_op = OP_NOP;
      sel_a  = '0;
      sel_b  = '0;
      if (gnt[0]) begin
         sel_op = bus.req0_op;
         sel_a  = bus.req0_a;
         sel_b  = bus.req0_b;
      end else if (gnt[1]) begin
         sel_op = bus.req1_op;
         sel_a  = bus.req1_a;
         sel_b  = bus.req1_b;
      end
   end

   // A nop never trusts the ALU output: result forced to zero and the
   // current flags reported back unchanged.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         flags_q      <= '0;
      end else if (accept) begin
         rsp_id_q <= gnt[1];
         if (sel_op == OP_NOP) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= flags_q;
         end else begin
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= bus.alu_flags_out;
         end
         if (op_updates_flags(sel_op)) flags_q <= bus.alu_flags_out;
      end
   end

   assign bus.req0_ready    = gnt[0];
   assign bus.req1_ready    = gnt[1];
   assign bus.alu_operand1  = sel_a;
   assign bus.alu_operand2  = sel_b;
   assign bus.alu_operation = sel_op;
   assign bus.alu_flags_in  = flags_q;
   assign bus.rsp_valid     = (state_q == RSP_FULL);
   assign bus.rsp_id        = rsp_id_q;
   assign bus.rsp_result    = rsp_result_q;
   assign bus.rsp_flags     = rsp_flags_q;
   assign bus.flags_q       = flags_q;

endmodule
